// File: rtl/lcd_msg_arbiter.sv
// Round-robin arbiter that shares one lcd_module text path between NUM_REQ sources.
// Latches the winner's two lines, kicks sendText once, then reports done or timeout.
module lcd_msg_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int LINE_LENGTH    = 16,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*8*LINE_LENGTH-1:0]  line1_in,
  input  logic [NUM_REQ*8*LINE_LENGTH-1:0]  line2_in,
  output logic [NUM_REQ-1:0]                grant,
  output logic [NUM_REQ-1:0]                done,
  output logic [NUM_REQ-1:0]                err,
  output logic                              busy,
  output logic                              lcd_sendText,
  output logic [8*LINE_LENGTH-1:0]          lcd_line1,
  output logic [8*LINE_LENGTH-1:0]          lcd_line2,
  input  logic                              lcd_sendingDone
);

  localparam int LW = 8 * LINE_LENGTH;
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);
  localparam logic [IW:0]   NUM_EXT  = (IW+1)'(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_KICK    = 3'd2,
    S_WAIT    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   ptr_r;
  logic [IW-1:0]   sel_r;
  logic [CW-1:0]   cnt_r;
  logic            prev_done_r;
  logic            ok_r;
  logic [IW-1:0]   pick_s;
  logic            found_s;
  logic [IW:0]     cand_s;
  logic            rise_s;

  assign rise_s = lcd_sendingDone & ~prev_done_r;

  // First requesting source at or after ptr, wrapping past NUM_REQ-1
  always_comb begin
    pick_s  = ptr_r;
    found_s = 1'b0;
    cand_s  = {(IW+1){1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = {1'b0, ptr_r} + (IW+1)'(i);
      if (cand_s >= NUM_EXT) begin
        cand_s = cand_s - NUM_EXT;
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s[IW-1:0]]) begin
        found_s = 1'b1;
        pick_s  = cand_s[IW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Sequencer: arbitration, line latching, kick, completion/timeout, release
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r      <= S_IDLE;
      ptr_r        <= {IW{1'b0}};
      sel_r        <= {IW{1'b0}};
      cnt_r        <= {CW{1'b0}};
      prev_done_r  <= 1'b0;
      ok_r         <= 1'b0;
      grant        <= {NUM_REQ{1'b0}};
      done         <= {NUM_REQ{1'b0}};
      err          <= {NUM_REQ{1'b0}};
      busy         <= 1'b0;
      lcd_sendText <= 1'b0;
      lcd_line1    <= {LINE_LENGTH{8'h20}};
      lcd_line2    <= {LINE_LENGTH{8'h20}};
    end else begin
      prev_done_r  <= lcd_sendingDone;
      done         <= {NUM_REQ{1'b0}};
      err          <= {NUM_REQ{1'b0}};
      lcd_sendText <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (found_s) begin
            sel_r   <= pick_s;
            grant   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
            busy    <= 1'b1;
            state_r <= S_LOAD;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_LOAD: begin
          lcd_line1 <= line1_in[sel_r*LW +: LW];
          lcd_line2 <= line2_in[sel_r*LW +: LW];
          cnt_r     <= {CW{1'b0}};
          state_r   <= S_KICK;
        end
        S_KICK: begin
          lcd_sendText <= 1'b1;
          state_r      <= S_WAIT;
        end
        S_WAIT: begin
          // A completion edge beats a timeout landing in the same cycle
          if (rise_s) begin
            ok_r    <= 1'b1;
            state_r <= S_RELEASE;
          end else if (cnt_r == CNT_LAST) begin
            ok_r    <= 1'b0;
            state_r <= S_RELEASE;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
          end
        end
        S_RELEASE: begin
          if (ok_r) begin
            done[sel_r] <= 1'b1;
          end else begin
            err[sel_r]  <= 1'b1;
          end
          grant   <= {NUM_REQ{1'b0}};
          ptr_r   <= (sel_r == IDX_LAST) ? {IW{1'b0}} : sel_r + IW'(1);
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          grant   <= {NUM_REQ{1'b0}};
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Bench for lcd_msg_arbiter: vector table of transfers, an LCD completion model,
// and a scoreboard of expected done/err pulses checked when the DUT emits them.
module tb_lcd_msg_arbiter;

  localparam int N  = 4;
  localparam int LL = 16;
  localparam int LW = 8 * LL;
  localparam int T  = 50;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [N-1:0]    req;
  logic [N*LW-1:0] line1_in;
  logic [N*LW-1:0] line2_in;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic [N-1:0]    err;
  logic            busy;
  logic            lcd_sendText;
  logic [LW-1:0]   lcd_line1;
  logic [LW-1:0]   lcd_line2;
  logic            lcd_sendingDone;

  lcd_msg_arbiter #(.NUM_REQ(N), .LINE_LENGTH(LL), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .line1_in(line1_in), .line2_in(line2_in),
    .grant(grant), .done(done), .err(err), .busy(busy), .lcd_sendText(lcd_sendText),
    .lcd_line1(lcd_line1), .lcd_line2(lcd_line2), .lcd_sendingDone(lcd_sendingDone)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int idx;
    bit is_err;
    int lat_min;
    int lat_max;
  } exp_t;

  typedef struct {
    logic [N-1:0] rq;
    logic [N-1:0] rq_after;
    int           delay;    // cycles from kick to sendingDone rise, 0 = never
    int           drop;     // cycle after kick at which sendingDone falls
    int           exp_idx;
    bit           exp_err;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   kick_cyc = 0;
  int   kicks = 0;
  int   m_delay = 10;
  int   m_drop = 0;
  int   m_k = 0;
  bit   m_active = 1'b0;
  logic [LW-1:0] spaces = {LL{8'h20}};

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic logic [LW-1:0] pad(input string s);
    logic [LW-1:0] r;
    for (int j = 0; j < LL; j++) begin
      r[LW-1-8*j -: 8] = (j < s.len()) ? s[j] : 8'h20;
    end
    return r;
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // LCD model: after a kick, drop sendingDone at cycle m_drop, raise it at m_delay
  initial begin
    lcd_sendingDone = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (RESET) begin
        m_active = 1'b0;
        lcd_sendingDone = 1'b0;
      end else begin
        if (lcd_sendText) begin
          m_active = 1'b1;
          m_k = 0;
        end else if (m_active) begin
          m_k++;
        end
        if (m_active) begin
          if (m_k == m_drop) lcd_sendingDone = 1'b0;
          if (m_delay > 0 && m_k == m_delay) begin
            lcd_sendingDone = 1'b1;
            m_active = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: count kicks, pop the scoreboard on every done/err pulse
  initial begin : mon
    exp_t e;
    logic [N-1:0] exp_d;
    logic [N-1:0] exp_e;
    forever begin
      @(negedge CLK);
      if (lcd_sendText) begin
        kicks++;
        kick_cyc = cyc;
      end
      if ((done | err) != '0) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_pulse: got done=%b err=%b expected none", done, err);
        end else begin
          e = sb_q.pop_front();
          exp_d = e.is_err ? '0 : N'(1) << e.idx;
          exp_e = e.is_err ? N'(1) << e.idx : '0;
          chk("done", done, exp_d);
          chk("err", err, exp_e);
          chk("grant_at_pulse", grant, '0);
          chk_rng("latency", cyc - kick_cyc, e.lat_min, e.lat_max);
        end
      end
    end
  end

  task automatic serve(input vec_t v);
    logic [LW-1:0] l1;
    logic [LW-1:0] l2;
    int  k0;
    bit  fin;
    req = v.rq;
    m_delay = v.delay;
    m_drop = v.drop;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (grant != '0) break;
    end
    chk("grant", grant, N'(1) << v.exp_idx);
    chk("busy", busy, 1'b1);
    l1 = line1_in[v.exp_idx*LW +: LW];
    l2 = line2_in[v.exp_idx*LW +: LW];
    if (v.exp_err) sb_q.push_back('{v.exp_idx, 1'b1, T, T + 2});
    else           sb_q.push_back('{v.exp_idx, 1'b0, v.delay + 2, v.delay + 2});
    k0 = kicks;
    req = v.rq_after;
    repeat (3) @(negedge CLK);
    // Source text changes after LOAD must not reach the LCD
    line1_in[v.exp_idx*LW +: LW] = ~l1;
    fin = 1'b0;
    for (int n = 0; n < T + 100; n++) begin
      @(negedge CLK);
      #1;
      if (sb_q.size() == 0) begin
        fin = 1'b1;
        break;
      end
    end
    if (!fin) begin
      n_vec++;
      n_bad++;
      $display("FAIL completion_wait: got no pulse expected one for source %0d", v.exp_idx);
      sb_q.delete();
    end
    chk("line1", lcd_line1, l1);
    chk("line2", lcd_line2, l2);
    chk("kicks", kicks - k0, 1);
    line1_in[v.exp_idx*LW +: LW] = l1;
    @(negedge CLK);
    if (v.rq_after == '0) begin
      chk("idle_busy", busy, 1'b0);
      chk("idle_grant", grant, '0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    RESET = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) begin
      line1_in[i*LW +: LW] = pad(i == 0 ? "HELLO" : $sformatf("SRC%0d L1", i));
      line2_in[i*LW +: LW] = pad($sformatf("SRC%0d L2", i));
    end

    // Round-robin with all four held, then single, wrap, timeout, ptr advance, stale level
    tbl.push_back('{4'b1111, 4'b1111, 10, 0, 0, 1'b0});
    tbl.push_back('{4'b1111, 4'b1111, 10, 0, 1, 1'b0});
    tbl.push_back('{4'b1111, 4'b1111, 10, 0, 2, 1'b0});
    tbl.push_back('{4'b1111, 4'b1111, 10, 0, 3, 1'b0});
    tbl.push_back('{4'b1111, 4'b0000, 10, 0, 0, 1'b0});
    tbl.push_back('{4'b0001, 4'b0000, 20, 0, 0, 1'b0});
    tbl.push_back('{4'b1000, 4'b0000, 10, 0, 3, 1'b0});
    tbl.push_back('{4'b1001, 4'b1001, 10, 0, 0, 1'b0});
    tbl.push_back('{4'b1001, 4'b0000, 10, 0, 3, 1'b0});
    tbl.push_back('{4'b0100, 4'b0000,  0, 0, 2, 1'b1});
    tbl.push_back('{4'b0101, 4'b0000, 10, 0, 0, 1'b0});
    tbl.push_back('{4'b0010, 4'b0000, 15, 5, 1, 1'b0});

    repeat (2) @(negedge CLK);
    chk("rst_grant", grant, '0);
    chk("rst_done", done, '0);
    chk("rst_err", err, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_send", lcd_sendText, 1'b0);
    chk("rst_line1", lcd_line1, spaces);
    chk("rst_line2", lcd_line2, spaces);
    RESET = 1'b0;
    @(negedge CLK);

    foreach (tbl[i]) serve(tbl[i]);

    // Reset five cycles after the kick of an in-flight transfer
    req = 4'b0001;
    m_delay = 30;
    m_drop = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (grant != '0) break;
    end
    chk("rw_grant", grant, 4'b0001);
    req = '0;
    begin
      int k0;
      k0 = kicks;
      for (int n = 0; n < 10; n++) begin
        @(negedge CLK);
        if (kicks != k0) break;
      end
      chk("rw_kick", kicks - k0, 1);
    end
    repeat (5) @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("rw_grant0", grant, '0);
    chk("rw_busy0", busy, 1'b0);
    chk("rw_send0", lcd_sendText, 1'b0);
    chk("rw_done0", done, '0);
    chk("rw_err0", err, '0);
    chk("rw_line1", lcd_line1, spaces);
    chk("rw_line2", lcd_line2, spaces);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    v = '{4'b1111, 4'b0000, 10, 0, 0, 1'b0};
    serve(v);

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
